// File: rtl/cp0_m.sv
// cp0_m: Coprocessor 0 for the M stage of the 5-stage MIPS pipeline.
// Holds SR, Cause, EPC and PrID. Arbitrates hardware interrupts against
// exceptions carried down the pipe, and raises Req to flush and redirect.
//
// Optional feature: define CP0_TIMER_EN to add Count(9)/Compare(11) and a
// timer interrupt that is OR-ed onto HWInt[5].
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all CP0 state
//   en         in   1   mtc0 write enable
//   CP0Add     in   5   register number for mtc0/mfc0
//   CP0In      in  32   mtc0 write data
//   VPC        in  32   PC of the instruction in M
//   BDIn       in   1   M instruction is in a branch delay slot
//   ExcCodeIn  in   5   exception code carried to M (0 = none)
//   HWInt      in   6   external interrupt lines, level-sensitive
//   EXLClr     in   1   eret is in M
//   CPOut      out 32   combinational read of register CP0Add
//   EPCOut     out 32   current EPC
//   HandlerPC  out 32   exception entry address
//   Req        out  1   take interrupt/exception this cycle (combinational)
module cp0_m #(
  parameter logic [31:0] PRID       = 32'h4255_4141,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CPOut,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC,
  output logic        Req
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic [5:0]  w_hwint;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_en;
  logic [31:0] w_epc_next;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_pend;

  // Timer pending shares the HWInt[5] line
  assign w_hwint = {HWInt[5] | r_timer_pend, HWInt[4:0]};
`else
  assign w_hwint = HWInt;
`endif

  // Request arbitration; EXL masks both sources, reset forces Req low
  assign w_int_req = (|(w_hwint & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  assign w_req     = ~reset & (w_int_req | w_exc_req);
  assign Req       = w_req;

  // An mtc0 coinciding with a taken request is discarded
  assign w_wr_en    = en & ~w_req;
  assign w_epc_next = BDIn ? (VPC - 32'd4) : VPC;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};

  assign EPCOut    = r_epc;
  assign HandlerPC = HANDLER_PC;

  // mfc0 read mux
  always_comb begin
    CPOut = 32'd0;
    case (CP0Add)
      REG_SR:      CPOut = w_sr;
      REG_CAUSE:   CPOut = w_cause;
      REG_EPC:     CPOut = r_epc;
      REG_PRID:    CPOut = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   CPOut = r_count;
      REG_COMPARE: CPOut = r_compare;
`endif
      default:     CPOut = 32'd0;
    endcase
  end

  // SR / Cause / EPC update: request beats eret, eret beats the SR.EXL write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= w_hwint;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
        r_bd      <= BDIn;
        r_epc     <= {w_epc_next[31:2], 2'b00};
      end else begin
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
        if (w_wr_en && (CP0Add == REG_SR)) begin
          r_im <= CP0In[15:10];
          r_ie <= CP0In[0];
          if (!EXLClr) begin
            r_exl <= CP0In[1];
          end
        end
        if (w_wr_en && (CP0Add == REG_EPC)) begin
          r_epc <= CP0In;
        end
      end
    end
  end

`ifdef CP0_TIMER_EN
  // Free-running Count, Compare match latches TimerPend until Compare is rewritten
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= 32'd0;
      r_compare    <= 32'd0;
      r_timer_pend <= 1'b0;
    end else begin
      if (w_wr_en && (CP0Add == REG_COUNT)) begin
        r_count <= CP0In;
      end else begin
        r_count <= r_count + 32'd1;
      end
      if (w_wr_en && (CP0Add == REG_COMPARE)) begin
        r_compare    <= CP0In;
        r_timer_pend <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_timer_pend <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cp0_m.sv
// tb_cp0_m: directed self-checking bench for cp0_m.
module tb_cp0_m;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CPOut;
  logic [31:0] EPCOut;
  logic [31:0] HandlerPC;
  logic        Req;

  int n_tests;
  int n_fail;

  cp0_m dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .CPOut     (CPOut),
    .EPCOut    (EPCOut),
    .HandlerPC (HandlerPC),
    .Req       (Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select a register for mfc0 and let the read mux settle
  task automatic rd(input logic [4:0] a);
    CP0Add = a;
    #1;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; CP0Add = a; CP0In = d;
    tick();
    en = 1'b0; CP0In = 32'd0;
  endtask

  task automatic test_reset();
    ExcCodeIn = 5'd5;
    rd(5'd15);
    n_tests++; if (CPOut !== 32'h4255_4141) begin n_fail++; $display("FAIL reset_prid: got %h exp %h", CPOut, 32'h4255_4141); end
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", Req); end
    ExcCodeIn = 5'd0;
    rd(5'd12);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL reset_sr: got %h exp 0", CPOut); end
    rd(5'd13);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL reset_cause: got %h exp 0", CPOut); end
    rd(5'd14);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %h exp 0", CPOut); end
    n_tests++; if (EPCOut !== 32'd0) begin n_fail++; $display("FAIL reset_epcout: got %h exp 0", EPCOut); end
    n_tests++; if (HandlerPC !== 32'h0000_4180) begin n_fail++; $display("FAIL handler_pc: got %h exp %h", HandlerPC, 32'h0000_4180); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_interrupt();
    do_mtc0(5'd12, 32'h0000_0401);
    rd(5'd12);
    n_tests++; if (CPOut !== 32'h0000_0401) begin n_fail++; $display("FAIL int_sr_write: got %h exp %h", CPOut, 32'h0000_0401); end
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL int_idle_req: got %b exp 0", Req); end
    HWInt = 6'b000001; VPC = 32'h0000_3008; BDIn = 1'b0;
    #1;
    n_tests++; if (Req !== 1'b1) begin n_fail++; $display("FAIL int_req: got %b exp 1", Req); end
    tick();
    HWInt = 6'd0;
    rd(5'd12);
    n_tests++; if (CPOut !== 32'h0000_0403) begin n_fail++; $display("FAIL int_sr_exl: got %h exp %h", CPOut, 32'h0000_0403); end
    rd(5'd13);
    n_tests++; if (CPOut !== 32'h0000_0400) begin n_fail++; $display("FAIL int_cause: got %h exp %h", CPOut, 32'h0000_0400); end
    n_tests++; if (EPCOut !== 32'h0000_3008) begin n_fail++; $display("FAIL int_epc: got %h exp %h", EPCOut, 32'h0000_3008); end
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL int_req_after: got %b exp 0", Req); end
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd(5'd12);
    n_tests++; if (CPOut !== 32'h0000_0401) begin n_fail++; $display("FAIL eret_sr: got %h exp %h", CPOut, 32'h0000_0401); end
  endtask

  task automatic test_exception_bd();
    ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h0000_3010;
    #1;
    n_tests++; if (Req !== 1'b1) begin n_fail++; $display("FAIL exc_req: got %b exp 1", Req); end
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd(5'd13);
    n_tests++; if (CPOut !== 32'h8000_0028) begin n_fail++; $display("FAIL exc_cause: got %h exp %h", CPOut, 32'h8000_0028); end
    n_tests++; if (EPCOut !== 32'h0000_300C) begin n_fail++; $display("FAIL exc_epc_bd: got %h exp %h", EPCOut, 32'h0000_300C); end
  endtask

  task automatic test_exl_mask();
    ExcCodeIn = 5'd4; HWInt = 6'b111111; VPC = 32'h0000_5000;
    #1;
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL exl_mask_req: got %b exp 0", Req); end
    tick();
    ExcCodeIn = 5'd0;
    n_tests++; if (EPCOut !== 32'h0000_300C) begin n_fail++; $display("FAIL exl_epc_hold: got %h exp %h", EPCOut, 32'h0000_300C); end
    rd(5'd13);
    n_tests++; if (CPOut !== 32'h8000_FC28) begin n_fail++; $display("FAIL exl_cause_ip: got %h exp %h", CPOut, 32'h8000_FC28); end
    EXLClr = 1'b1;
    #1;
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL eret_cycle_req: got %b exp 0", Req); end
    tick();
    EXLClr = 1'b0;
    VPC = 32'h0000_6000;
    #1;
    n_tests++; if (Req !== 1'b1) begin n_fail++; $display("FAIL reassert_req: got %b exp 1", Req); end
    tick();
    HWInt = 6'd0;
    n_tests++; if (EPCOut !== 32'h0000_6000) begin n_fail++; $display("FAIL reassert_epc: got %h exp %h", EPCOut, 32'h0000_6000); end
    rd(5'd13);
    n_tests++; if (CPOut !== 32'h0000_FC00) begin n_fail++; $display("FAIL reassert_cause: got %h exp %h", CPOut, 32'h0000_FC00); end
  endtask

  task automatic test_eret_sr_write();
    EXLClr = 1'b1;
    do_mtc0(5'd12, 32'h0000_0003);
    EXLClr = 1'b0;
    rd(5'd12);
    n_tests++; if (CPOut !== 32'h0000_0001) begin n_fail++; $display("FAIL eret_vs_sr_exl: got %h exp %h", CPOut, 32'h0000_0001); end
  endtask

  task automatic test_mtc0_discard();
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h1234_5678;
    ExcCodeIn = 5'd12; VPC = 32'h0000_7001; BDIn = 1'b0;
    #1;
    n_tests++; if (Req !== 1'b1) begin n_fail++; $display("FAIL discard_req: got %b exp 1", Req); end
    tick();
    en = 1'b0; ExcCodeIn = 5'd0; CP0In = 32'd0;
    n_tests++; if (EPCOut !== 32'h0000_7000) begin n_fail++; $display("FAIL discard_epc: got %h exp %h", EPCOut, 32'h0000_7000); end
    rd(5'd13);
    n_tests++; if (CPOut !== 32'h0000_0030) begin n_fail++; $display("FAIL discard_cause: got %h exp %h", CPOut, 32'h0000_0030); end
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
  endtask

  task automatic test_mtc0_regs();
    do_mtc0(5'd14, 32'h1234_5679);
    n_tests++; if (EPCOut !== 32'h1234_5679) begin n_fail++; $display("FAIL mtc0_epc: got %h exp %h", EPCOut, 32'h1234_5679); end
    do_mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13);
    n_tests++; if (CPOut !== 32'h0000_0030) begin n_fail++; $display("FAIL mtc0_cause_ro: got %h exp %h", CPOut, 32'h0000_0030); end
    do_mtc0(5'd15, 32'h0000_0000);
    rd(5'd15);
    n_tests++; if (CPOut !== 32'h4255_4141) begin n_fail++; $display("FAIL mtc0_prid_ro: got %h exp %h", CPOut, 32'h4255_4141); end
    do_mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12);
    n_tests++; if (CPOut !== 32'h0000_FC03) begin n_fail++; $display("FAIL mtc0_sr_mask: got %h exp %h", CPOut, 32'h0000_FC03); end
    rd(5'd0);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL rd_reg0: got %h exp 0", CPOut); end
    rd(5'd31);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL rd_reg31: got %h exp 0", CPOut); end
`ifndef CP0_TIMER_EN
    do_mtc0(5'd11, 32'h0000_0055);
    rd(5'd11);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL rd_reg11: got %h exp 0", CPOut); end
    rd(5'd9);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL rd_reg9: got %h exp 0", CPOut); end
`endif
    ExcCodeIn = 5'd7;
    #1;
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL sr_exl_mask_req: got %b exp 0", Req); end
  endtask

  task automatic test_async_reset();
    ExcCodeIn = 5'd3;
    reset = 1'b1;
    #1;
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL async_req: got %b exp 0", Req); end
    n_tests++; if (EPCOut !== 32'd0) begin n_fail++; $display("FAIL async_epc: got %h exp 0", EPCOut); end
    rd(5'd12);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL async_sr: got %h exp 0", CPOut); end
    rd(5'd13);
    n_tests++; if (CPOut !== 32'd0) begin n_fail++; $display("FAIL async_cause: got %h exp 0", CPOut); end
    rd(5'd15);
    n_tests++; if (CPOut !== 32'h4255_4141) begin n_fail++; $display("FAIL async_prid: got %h exp %h", CPOut, 32'h4255_4141); end
    ExcCodeIn = 5'd0;
    tick();
    reset = 1'b0;
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    do_mtc0(5'd12, 32'h0000_8001);
    do_mtc0(5'd9, 32'd15);
    do_mtc0(5'd11, 32'd20);
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (Req !== 1'b0) begin n_fail++; $display("FAIL timer_early: got %b exp 0", Req); end
    tick();
    n_tests++; if (Req !== 1'b1) begin n_fail++; $display("FAIL timer_req: got %b exp 1", Req); end
    VPC = 32'h0000_8000;
    tick();
    do_mtc0(5'd11, 32'd100);
    tick();
    rd(5'd13);
    n_tests++; if ((CPOut & 32'h0000_8000) !== 32'd0) begin n_fail++; $display("FAIL timer_pend_clr: got %h exp 0", CPOut & 32'h0000_8000); end
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    #2;
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_exl_mask();
    test_eret_sr_write();
    test_mtc0_discard();
    test_mtc0_regs();
    test_async_reset();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_m.md
Name: cp0_m

Overview:
- Coprocessor 0 for the M stage of the 5-stage MIPS pipeline.
- Holds the SR, Cause, EPC and PrID registers, and arbitrates between hardware interrupts and exceptions carried down the pipe.
- Drives CPOut (mfc0 data, captured into W as CPOutM) and Req (flushes every pipeline register, including W, and redirects PC to the handler).
- EPCOut feeds the eret target mux in the fetch stage.

Parameters:
- PRID, 32'h4255_4141, read-only value returned for register 15.
- HANDLER_PC, 32'h0000_4180, exception entry address driven on HandlerPC.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all CP0 state
- en  input  1  mtc0 write enable from the M-stage instruction
- CP0Add  input  5  register number for mtc0/mfc0
- CP0In  input  32  mtc0 write data (forwarded rt value)
- VPC  input  32  PC of the instruction currently in M
- BDIn  input  1  M instruction sits in a branch delay slot
- ExcCodeIn  input  5  exception code carried to M; 0 = none
- HWInt  input  6  external interrupt lines, level-sensitive
- EXLClr  input  1  eret is in M
- CPOut  output  32  combinational read of register CP0Add
- EPCOut  output  32  current EPC value
- HandlerPC  output  32  constant HANDLER_PC
- Req  output  1  take interrupt/exception this cycle

Behaviour:
- Register layout:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): full 32 bits.
  - PrID(15): PRID.
  - Any other CP0Add reads 0.
- Reset (asynchronous): IM=0, EXL=0, IE=0, BD=0, IP=0, ExcCode=0, EPC=0.
  - Outputs during reset: CPOut follows CP0Add (PrID still readable), EPCOut=0, Req=0.
- IntReq = |(HWInt & IM) & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq. Combinational, same cycle as the inputs. Interrupt has priority over exception.
- IP is written from HWInt every rising edge regardless of the other controls.
- On a rising edge with Req=1:
  - EXL<=1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD<=BDIn.
  - EPC <= BDIn ? (VPC-4) : VPC, then low 2 bits forced to 0.
  - A simultaneous mtc0 (en=1) is discarded.
- Else if EXLClr=1: EXL<=0. A simultaneous en is also honoured. If en targets SR, the written EXL bit loses to EXLClr.
- Else if en=1, register by CP0Add:
  - 12: load IM/EXL/IE from CP0In.
  - 14: load EPC from CP0In unaligned.
  - 13, 15 and all others: ignored.
- While EXL=1, Req is held at 0: no nesting, and further ExcCodeIn values are ignored.
- Read/write hazard: CPOut reflects the pre-edge value. A same-cycle mtc0/mfc0 pair does not occur, because the pipeline stalls it upstream.
- Exception flush: the M instruction that raised Req does not write W (the W register flushes on Req).

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined:
  - Adds Count(9) and Compare(11), both reset to 0.
  - Count increments every cycle with 32-bit wrap.
  - mtc0 to 9 or 11 loads the register. Writing 11 also clears TimerPend.
  - TimerPend sets when Count==Compare and Compare!=0.
  - TimerPend is OR-ed into HWInt[5] for both IntReq and IP.
- Undefined: registers 9 and 11 read 0 and writes are ignored. HWInt[5] comes only from the external pin.

Test Plan:
- Reset, then CP0Add=15/12/13/14 -> CPOut=PRID/0/0/0, Req=0, EPCOut=0.
- mtc0 SR=32'h0000_0401, then HWInt=6'b000001, VPC=32'h0000_3008, BDIn=0 -> Req=1 that cycle; after edge SR=32'h0000_0403, ExcCode=0, IP[10]=1, EPC=32'h0000_3008.
- EXL=0, ExcCodeIn=5'd10, BDIn=1, VPC=32'h0000_3010 -> Req=1; after edge Cause=32'h8000_0028, EPC=32'h0000_300C.
- EXL=1, ExcCodeIn=5'd4 with HWInt=6'b111111 -> Req=0, EPC unchanged; then EXLClr=1 -> EXL=0, Req re-asserts next cycle if IM/IE still allow it.
- Same cycle en=1, CP0Add=14, CP0In=32'h1234_5678, ExcCodeIn=5'd12 -> EPC=VPC (aligned), write discarded; reset asserted mid-stream -> all state 0 immediately without a clock edge.
- CP0_TIMER_EN: SR=32'h0000_8001, Compare=32'd20 -> Req rises when Count reaches 20; mtc0 Compare -> TimerPend clears.
